aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl_pkg.sv | 31 +++
 rtl/aes_round_ctrl.sv | 92 +++++++++
 tb/tb_aes_round_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_pkg.sv
// Shared AES-128 definitions: controller states,
// round count and the key-schedule round constants.
package aes_round_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  localparam int NR_AES128 = 10;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: one round per clock
// through an external combinational datapath and key schedule.
module aes_round_ctrl
  import aes_round_ctrl_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  output logic [127:0] dp_state,
  output logic [127:0] dp_key,
  output logic         dp_final,
  input  logic [127:0] dp_result,
  output logic [127:0] ks_key,
  output logic [7:0]   ks_rcon,
  input  logic [127:0] ks_next,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);

  localparam logic [3:0] NR_W = 4'(NR);

  state_t       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] sreg_q, sreg_d;
  logic [127:0] kreg_q, kreg_d;
  logic         last;

  assign last     = (round_q == NR_W);
  assign busy     = (state_q != IDLE);
  assign dp_state = sreg_q;
  assign ks_key   = kreg_q;
  assign dp_key   = ks_next;

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    sreg_d    = sreg_q;
    kreg_d    = kreg_q;
    in_ready  = 1'b0;
    dp_final  = 1'b0;
    ks_rcon   = 8'h00;
    out_valid = 1'b0;
    out_block = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ROUND;
          round_d = 4'd1;
          sreg_d  = in_block ^ in_key;
          kreg_d  = in_key;
        end
      end
      ROUND: begin
        dp_final = last;
        ks_rcon  = rcon(round_q);
        sreg_d   = dp_result;
        kreg_d   = ks_next;
        if (last) state_d = DONE;
        else      round_d = round_q + 4'd1;
      end
      DONE: begin
        out_valid = 1'b1;
        out_block = sreg_q;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      sreg_q  <= '0;
      kreg_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      sreg_q  <= sreg_d;
      kreg_q  <= kreg_d;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a behavioural
// AES-128 round datapath and key schedule around it.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [127:0] in_key;
  logic [127:0] dp_state;
  logic [127:0] dp_key;
  logic         dp_final;
  logic [127:0] dp_result;
  logic [127:0] ks_key;
  logic [7:0]   ks_rcon;
  logic [127:0] ks_next;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_hs = -1;

  localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;

  logic [7:0] rc_exp [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  aes_round_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .in_key    (in_key),
    .dp_state  (dp_state),
    .dp_key    (dp_key),
    .dp_final  (dp_final),
    .dp_result (dp_result),
    .ks_key    (ks_key),
    .ks_rcon   (ks_rcon),
    .ks_next   (ks_next),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] t = x;
    for (int i = 1; i < 8; i++) begin
      t = gm(t, t);
      r = gm(r, t);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] st,
                                            input logic [127:0] k,
                                            input logic fin);
    logic [7:0]   b [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[4*c+r] = sb(st[127-8*(4*((c+r)%4)+r) -: 8]);
    for (int c = 0; c < 4; c++) begin
      a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
      if (!fin) begin
        b[4*c]   = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
        b[4*c+1] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
        b[4*c+2] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
        b[4*c+3] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] key_fn(input logic [127:0] k,
                                          input logic [7:0] rc);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = k[31:0];
    t  = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])};
    t  = t ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign ks_next   = key_fn(ks_key, ks_rcon);
  assign dp_result = round_fn(dp_state, dp_key, dp_final);

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vector(input logic [127:0] k, input logic [127:0] pt,
                            input logic [127:0] ct, input int hold,
                            input bit keep_valid);
    in_key   = k;
    in_block = pt;
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    if (keep_valid && last_hs >= 0) chk("issue_interval", cyc - last_hs, 12);
    last_hs = cyc;
    step();
    in_key   = ~k;
    in_block = ~pt;
    for (int r = 1; r <= 10; r++) begin
      chk($sformatf("rcon_r%0d", r), ks_rcon, rc_exp[r]);
      chk($sformatf("final_r%0d", r), dp_final, (r == 10));
      chk($sformatf("noval_r%0d", r), out_valid, 0);
      chk($sformatf("busy_r%0d", r), busy, 1);
      step();
    end
    chk("out_valid_done", out_valid, 1);
    chk("out_block_done", out_block, ct);
    out_ready = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_block", out_block, ct);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid  = keep_valid;
    step();
    if (!keep_valid) begin
      chk("post_valid", out_valid, 0);
      chk("post_in_ready", in_ready, 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_block = '0;
    in_key = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_block", out_block, 0);
    chk("rst_final", dp_final, 0);
    chk("rst_rcon", ks_rcon, 0);

    out_ready = 1'b1;
    run_vector(KA, PA, CA, 0, 1'b0);
    out_ready = 1'b0;
    run_vector(KB, PB, CB, 5, 1'b0);

    in_key = KA;
    in_block = PA;
    in_valid = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    chk("mid_rcon_r5", ks_rcon, 8'h10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_rcon", ks_rcon, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("midrst_no_out", out_valid, 0);
    end
    out_ready = 1'b1;
    run_vector(KB, PB, CB, 0, 1'b0);

    last_hs = -1;
    run_vector(KA, PA, CA, 0, 1'b1);
    run_vector(KB, PB, CB, 0, 1'b1);
    run_vector(KA, PA, CA, 0, 1'b1);
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
